// File: rtl/ser2par_pkg.sv
// Shared definitions for the ser2par serial-to-parallel receiver.
//   state_t   : receiver FSM states (IDLE, SHIFT)
//   cnt_w()   : bit-counter width able to hold 0..width
//   width_ok(): legal word-length check
package ser2par_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned CNT_W_MAX = $clog2(WIDTH_MAX + 1);

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/ser2par_shift.sv
// Shift register plus bit counter for the ser2par receiver.
//   clock, reset : system clock, synchronous active-high reset
//   load         : start a new word with bit_in as its first bit (count=1)
//   shift        : append bit_in to the word in progress (count+1)
//   clear        : return the counter to 0 (word complete)
//   bit_in       : serial data bit
//   word_next    : word value after this edge's load/shift
//   done         : this edge's shift completes the word
module ser2par_shift
  import ser2par_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] count;

  always_comb begin
    word_next = sr;
    if (load) begin
      if (MSB_FIRST) word_next = {{(WIDTH-1){1'b0}}, bit_in};
      else           word_next = {bit_in, {(WIDTH-1){1'b0}}};
    end else if (shift) begin
      if (MSB_FIRST) word_next = {sr[WIDTH-2:0], bit_in};
      else           word_next = {bit_in, sr[WIDTH-1:1]};
    end
  end

  // Load always wins over shift, so a restarting sof can never complete a word.
  assign done = shift && !load && (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      sr    <= '0;
      count <= '0;
    end else begin
      if (load || shift) sr <= word_next;
      if (clear)      count <= '0;
      else if (load)  count <= CNT_W'(1);
      else if (shift) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver: frames WIDTH bits after a start-of-frame
// strobe and presents the word on a valid/ready output.
//   clock, reset : system clock, synchronous active-high reset
//   d, d_valid   : serial bit and its qualifier
//   sof          : first bit of a frame (with d_valid)
//   q, q_valid   : assembled word and its valid flag
//   q_ready      : consumer accepts q when q_valid & q_ready
//   busy         : frame in progress
//   frame_err    : sticky, sof seen mid-frame
//   overrun      : sticky, completed word dropped (output occupied)
//   err_clr      : clears frame_err and overrun (a same-edge set wins)
//
// state | meaning
// IDLE  | waiting for sof
// SHIFT | collecting bits 2..WIDTH of a frame
module ser2par_rx
  import ser2par_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d,
  input  logic             d_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("ser2par_rx: WIDTH out of range 2..32");
  end

  state_t           state, state_next;
  logic             load, shift_en, abort, done;
  logic [WIDTH-1:0] word_next;
  logic             slot_free;

  ser2par_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift     (shift_en),
    .clear     (done),
    .bit_in    (d),
    .word_next (word_next),
    .done      (done)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (d_valid && sof) state_next = SHIFT;
      SHIFT:   if (done)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = d_valid && sof;
    shift_en = (state == SHIFT) && d_valid && !sof;
    abort    = (state == SHIFT) && d_valid && sof;
    busy     = (state == SHIFT);
  end

  // A held word being accepted this cycle frees the slot for the new one.
  assign slot_free = !q_valid || q_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (done && slot_free) begin
        q       <= word_next;
        q_valid <= 1'b1;
      end else if (q_ready) begin
        q_valid <= 1'b0;
      end

      if (abort)        frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;

      if (done && !slot_free) overrun <= 1'b1;
      else if (err_clr)       overrun <= 1'b0;
    end
  end

endmodule
